scratch_sdram_responder: RTL and testbench

//  Serves the game core's ROM request port (sdram_req/sdram_addr -> sdram_ack,

---
 rtl/scratch_sdram_responder_if.sv | 10 +
 rtl/scratch_sdram_responder.sv | 98 +++++++++
 tb/tb_scratch_sdram_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/scratch_sdram_responder_if.sv
// scratch_sdram_responder_if: game-side ROM request handshake bundle
interface scratch_sdram_responder_if;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic [31:0] data_read;
    logic        data_rdy;
    modport master (output sdram_req, sdram_addr, input sdram_ack, data_read, data_rdy);
    modport slave (input sdram_req, sdram_addr, output sdram_ack, data_read, data_rdy);
endinterface

// File: rtl/scratch_sdram_responder.sv
// scratch_sdram_responder: turns game ROM requests into two 16-bit reads, inserts refresh windows
module scratch_sdram_responder #(
    parameter int REFRESH_CYCLES = 8,
    parameter int TIMEOUT        = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    scratch_sdram_responder_if.slave        game,
    input  logic                            refresh_en,
    input  logic                            downloading,
    output logic [21:0]                     mem_addr,
    output logic                            mem_rd,
    input  logic [15:0]                     mem_din,
    input  logic                            mem_valid,
    output logic                            busy,
    output logic                            err
);
    localparam int CMAX = TIMEOUT > REFRESH_CYCLES ? TIMEOUT : REFRESH_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    typedef enum logic [2:0] {IDLE, ACK, RD_LO, WT_LO, RD_HI, WT_HI, DONE, REFRESH} state_t;
    state_t        state;
    logic [21:0]   addr;
    logic [15:0]   lo, hi;
    logic [CW-1:0] cnt;
    logic          timed_out;
    assign timed_out = cnt == CW'(TIMEOUT);
    assign busy      = state != IDLE;
    // Request FSM: strobes are set on entry to the state they belong to, data_rdy on leaving DONE
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            addr           <= '0;
            lo             <= '0;
            hi             <= '0;
            cnt            <= '0;
            mem_addr       <= '0;
            mem_rd         <= 1'b0;
            err            <= 1'b0;
            game.sdram_ack <= 1'b0;
            game.data_read <= '0;
            game.data_rdy  <= 1'b0;
        end else begin
            game.sdram_ack <= 1'b0;
            game.data_rdy  <= 1'b0;
            mem_rd         <= 1'b0;
            case (state)
                IDLE:
                    if (!downloading && game.sdram_req) begin
                        addr           <= game.sdram_addr;
                        game.sdram_ack <= 1'b1;
                        state          <= ACK;
                    end else if (!downloading && refresh_en) begin
                        cnt   <= '0;
                        state <= REFRESH;
                    end
                ACK: begin
                    mem_addr <= addr;
                    mem_rd   <= 1'b1;
                    state    <= RD_LO;
                end
                RD_LO: begin
                    cnt   <= '0;
                    state <= WT_LO;
                end
                WT_LO:
                    if (mem_valid || timed_out) begin
                        lo       <= mem_valid ? mem_din : 16'hFFFF;
                        err      <= err | !mem_valid;
                        mem_addr <= addr + 22'd1;
                        mem_rd   <= 1'b1;
                        state    <= RD_HI;
                    end else
                        cnt <= cnt + CW'(1);
                RD_HI: begin
                    cnt   <= '0;
                    state <= WT_HI;
                end
                WT_HI:
                    if (mem_valid || timed_out) begin
                        hi    <= mem_valid ? mem_din : 16'hFFFF;
                        err   <= err | !mem_valid;
                        state <= DONE;
                    end else
                        cnt <= cnt + CW'(1);
                DONE: begin
                    game.data_read <= {hi, lo};
                    game.data_rdy  <= 1'b1;
                    state          <= IDLE;
                end
                REFRESH:
                    if (cnt == CW'(REFRESH_CYCLES - 1))
                        state <= IDLE;
                    else
                        cnt <= cnt + CW'(1);
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_scratch_sdram_responder.sv
// tb_scratch_sdram_responder: directed scenarios with an address/data scoreboard and a memory model
module tb_scratch_sdram_responder;
    localparam int R  = 8;
    localparam int TO = 4;
    logic        clk = 0, rst_n = 0, refresh_en = 0, downloading = 0, mem_valid = 0;
    logic [15:0] mem_din = 0;
    logic [21:0] mem_addr;
    logic        mem_rd, busy, err;
    int          checks = 0, errors = 0;
    logic [31:0] exp_data[$];
    logic [21:0] exp_addr[$];
    logic [15:0] mem[logic [21:0]];
    logic        mute_en = 0;
    logic [21:0] mute_addr = 0;
    logic        pend = 0;
    logic [21:0] pend_addr = 0;

    scratch_sdram_responder_if bus();

    scratch_sdram_responder #(.REFRESH_CYCLES(R), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .game(bus),
        .refresh_en(refresh_en),
        .downloading(downloading),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_din(mem_din),
        .mem_valid(mem_valid),
        .busy(busy),
        .err(err)
    );

    always #10 clk = ~clk;

    function automatic logic [15:0] rd(input logic [21:0] a);
        return mem.exists(a) ? mem[a] : (a[15:0] ^ 16'hA5A5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: answers each mem_rd one cycle later unless the address is muted
    initial forever begin
        @(posedge clk);
        #1;
        mem_valid = pend;
        mem_din   = pend ? rd(pend_addr) : 16'h0;
        pend      = 0;
        if (mem_rd) begin
            chk("mem_rd_expected", 32'(exp_addr.size() != 0), 1);
            if (exp_addr.size() != 0) chk("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
            pend      = !(mute_en && mem_addr == mute_addr);
            pend_addr = mem_addr;
        end
        if (bus.data_rdy) begin
            chk("data_rdy_expected", 32'(exp_data.size() != 0), 1);
            if (exp_data.size() != 0) chk("data_read", bus.data_read, exp_data.pop_front());
        end
    end

    task automatic run(input logic [21:0] a, input logic lo_to, input logic hi_to,
                       output int t_ack, output int t_rd, output int t_rdy);
        exp_addr.push_back(a);
        exp_addr.push_back(a + 22'd1);
        exp_data.push_back({hi_to ? 16'hFFFF : rd(a + 22'd1), lo_to ? 16'hFFFF : rd(a)});
        bus.sdram_req  = 1;
        bus.sdram_addr = a;
        t_ack = 0;
        t_rd  = 0;
        t_rdy = 0;
        for (int c = 1; c <= 100 && t_rdy == 0; c++) begin
            @(posedge clk);
            #1;
            if (bus.sdram_ack && t_ack == 0) begin
                t_ack = c;
                bus.sdram_req = 0;
            end
            if (mem_rd && t_rd == 0) t_rd = c;
            if (bus.data_rdy) t_rdy = c;
        end
        bus.sdram_req = 0;
        chk("run_completed", 32'(t_rdy != 0), 1);
    endtask

    initial begin
        int   ta, trd, tr;
        logic any_ack, any_busy;
        mem[22'h000100] = 16'hBEEF;
        mem[22'h000101] = 16'hCAFE;
        mem[22'h3FFFFF] = 16'h1234;
        mem[22'h000000] = 16'h5678;
        bus.sdram_req  = 0;
        bus.sdram_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({bus.sdram_ack, bus.data_rdy, mem_rd, busy, err}), 0);
        chk("rst_data_read", bus.data_read, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        run(22'h000100, 0, 0, ta, trd, tr);
        chk("t1_ack_lat", ta, 1);
        chk("t1_rd_lat", trd, 2);
        chk("t1_rdy_lat", tr, 7);
        chk("t1_data", bus.data_read, 32'hCAFEBEEF);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_hold", bus.data_read, 32'hCAFEBEEF);
        chk("t1_rdy_pulse", 32'(bus.data_rdy), 0);
        run(22'h3FFFFF, 0, 0, ta, trd, tr);
        chk("t2_data", bus.data_read, 32'h56781234);
        chk("t2_rdy_lat", tr, 7);
        refresh_en = 1;
        run(22'h000200, 0, 0, ta, trd, tr);
        chk("t3_req_wins", ta, 1);
        @(posedge clk);
        #1;
        chk("t3_refresh_busy", 32'(busy), 1);
        refresh_en = 0;
        run(22'h000300, 0, 0, ta, trd, tr);
        chk("t3_refresh_ack", ta, R + 1);
        downloading    = 1;
        bus.sdram_req  = 1;
        bus.sdram_addr = 22'h000400;
        any_ack  = 0;
        any_busy = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            any_ack  |= bus.sdram_ack;
            any_busy |= busy;
        end
        chk("t4_no_ack", 32'(any_ack), 0);
        chk("t4_not_busy", 32'(any_busy), 0);
        downloading = 0;
        run(22'h000400, 0, 0, ta, trd, tr);
        chk("t4_ack_after_dl", 32'(ta >= 1 && ta <= 2), 1);
        mute_en   = 1;
        mute_addr = 22'h000500;
        run(22'h000500, 1, 0, ta, trd, tr);
        mute_en = 0;
        chk("t5_err", 32'(err), 1);
        chk("t5_data", bus.data_read, {rd(22'h000501), 16'hFFFF});
        chk("t5_rdy_lat", tr, 7 + TO);
        run(22'h000600, 0, 0, ta, trd, tr);
        chk("t5_err_sticky", 32'(err), 1);
        mute_en   = 1;
        mute_addr = 22'h000701;
        exp_addr.push_back(22'h000700);
        exp_addr.push_back(22'h000701);
        bus.sdram_req  = 1;
        bus.sdram_addr = 22'h000700;
        @(posedge clk);
        #1;
        bus.sdram_req = 0;
        chk("t6_ack", 32'(bus.sdram_ack), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_busy_wt_hi", 32'(busy), 1);
        #5 rst_n = 0;
        #1;
        chk("t6_rst_ctrl", 32'({bus.sdram_ack, bus.data_rdy, mem_rd, busy, err}), 0);
        chk("t6_rst_data_read", bus.data_read, 0);
        chk("t6_rst_mem_addr", 32'(mem_addr), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n   = 1;
        mute_en = 0;
        @(posedge clk);
        #1;
        run(22'h000800, 0, 0, ta, trd, tr);
        chk("t6_after_rst_ack", ta, 1);
        chk("t6_after_rst_rdy", tr, 7);
        chk("t6_no_err", 32'(err), 0);
        chk("queues_empty", 32'(exp_addr.size() + exp_data.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
